// File: rtl/hv_commandq_gen2_if.sv
// Host-side bus bundle for hv_commandq_gen2: CDB ingest, dispatch, status update and query.
// The host drives through the master modport; the queue sits on the slave modport.
interface hv_commandq_gen2_if #(
  parameter int IO_WIDTH  = 64,
  parameter int TAG_WIDTH = 8
);
  logic                 cmd_ie;
  logic [IO_WIDTH-1:0]  cmd_in;
  logic                 cq_cin_ready;
  logic                 cmd_err;
  logic                 cmd_request;
  logic                 cq_cout_ready;
  logic                 cmd_oe;
  logic [IO_WIDTH-1:0]  cmd_out;
  logic                 status_we;
  logic [TAG_WIDTH-1:0] op_index;
  logic [7:0]           cmd_op_status;
  logic                 query_ie;
  logic [TAG_WIDTH-1:0] query_tag;
  logic                 query_oe;
  logic [IO_WIDTH-1:0]  query_out;

  modport master (
    output cmd_ie, cmd_in, cmd_request, status_we, op_index, cmd_op_status, query_ie, query_tag,
    input  cq_cin_ready, cmd_err, cq_cout_ready, cmd_oe, cmd_out, query_oe, query_out
  );

  modport slave (
    input  cmd_ie, cmd_in, cmd_request, status_we, op_index, cmd_op_status, query_ie, query_tag,
    output cq_cin_ready, cmd_err, cq_cout_ready, cmd_oe, cmd_out, query_oe, query_out
  );
endinterface

// File: rtl/hv_commandq_gen2.sv
// hv_commandq_gen2: host command queue. Ingests CDBs as IO_WIDTH-bit beats, stores them in
// tag-indexed slots, dispatches in arrival order and answers per-tag status queries.
// Optional feature macro: HV_CMDQ_CHECKSUM_EN (XOR checksum check on 32-bit word 4).
//
// Slot state     | meaning
// SLOT_FREE      | empty, may be written
// SLOT_PENDING   | committed, waiting in the order FIFO
// SLOT_ISSUED    | dispatched, awaiting completion status
// SLOT_DONE      | completed (READ_DONE/WRITE_DONE), queryable, overwritable
//
// Engine state   | meaning
// ENG_IDLE       | no dispatch/query in flight
// ENG_LAT        | snapshot taken, one cycle before the first beat
// ENG_STREAM     | driving cmd_out or query_out, one beat per cycle
module hv_commandq_gen2 #(
  parameter int IO_WIDTH  = 64,
  parameter int CDB_WIDTH = 256,
  parameter int DEPTH     = 8,
  parameter int TAG_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  hv_commandq_gen2_if.slave  bus
);
  localparam int BEATS = CDB_WIDTH / IO_WIDTH;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int BW    = $clog2(BEATS);

  localparam logic [BW-1:0]  BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0]  BEAT_LAST = BW'(BEATS - 1);
  localparam logic [IDX_W:0] PTR_ONE   = (IDX_W + 1)'(1);

  localparam logic [1:0] SLOT_FREE    = 2'd0;
  localparam logic [1:0] SLOT_PENDING = 2'd1;
  localparam logic [1:0] SLOT_ISSUED  = 2'd2;
  localparam logic [1:0] SLOT_DONE    = 2'd3;

  localparam logic [1:0] ENG_IDLE   = 2'd0;
  localparam logic [1:0] ENG_LAT    = 2'd1;
  localparam logic [1:0] ENG_STREAM = 2'd2;

  logic                 alive;
  logic [BW-1:0]        beat_cnt;
  logic [CDB_WIDTH-1:0] in_buf;
  logic                 commit_pend;
  logic                 trunc_err;

  logic [CDB_WIDTH-1:0] slot_cdb    [DEPTH];
  logic [1:0]           slot_state  [DEPTH];
  logic [7:0]           slot_status [DEPTH];
  logic [IDX_W-1:0]     order_mem   [DEPTH];
  logic [IDX_W:0]       wr_ptr, rd_ptr;

  logic [1:0]           eng_state;
  logic                 eng_query;
  logic [BW-1:0]        eng_beat;
  logic [CDB_WIDTH-1:0] snap;

  logic                 fifo_full, fifo_empty, cin_ready;
  logic [IDX_W-1:0]     in_idx, head_idx, q_idx, op_slot;
  logic                 in_busy, csum_ok, do_commit, do_reject;
  logic                 start_beat, pop, qry, q_hit, upd_ok;
  logic [CDB_WIDTH-1:0] q_resp;

  assign fifo_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign fifo_empty = (wr_ptr == rd_ptr);
  // alive keeps cq_cin_ready low while reset is held and for the first cycle after release
  assign cin_ready  = alive && !fifo_full && !commit_pend;

  assign in_idx     = in_buf[8 +: IDX_W];
  assign in_busy    = (slot_state[in_idx] == SLOT_PENDING) || (slot_state[in_idx] == SLOT_ISSUED);
  assign do_commit  = commit_pend && csum_ok && !in_busy;
  assign do_reject  = commit_pend && !do_commit;
  assign start_beat = bus.cmd_ie && (beat_cnt == '0) && cin_ready;

  assign head_idx   = order_mem[rd_ptr[IDX_W-1:0]];
  // a dispatch request wins over a query arriving in the same idle cycle
  assign pop        = bus.cmd_request && !fifo_empty && (eng_state == ENG_IDLE);
  assign qry        = bus.query_ie && (eng_state == ENG_IDLE) && !pop;

  assign q_idx      = bus.query_tag[IDX_W-1:0];
  assign q_hit      = (slot_state[q_idx] != SLOT_FREE) &&
                      (slot_cdb[q_idx][8 +: TAG_WIDTH] == bus.query_tag);

  assign op_slot    = bus.op_index[IDX_W-1:0];
  assign upd_ok     = bus.status_we && (slot_state[op_slot] == SLOT_ISSUED) &&
                      (slot_cdb[op_slot][8 +: TAG_WIDTH] == bus.op_index);

  // Checksum: word 4 equals XOR of the others, i.e. all words XOR to zero
  always_comb begin
    csum_ok = 1'b1;
`ifdef HV_CMDQ_CHECKSUM_EN
    begin
      logic [31:0] acc;
      acc = '0;
      for (int w = 0; w < CDB_WIDTH / 32; w++) acc = acc ^ in_buf[w*32 +: 32];
      csum_ok = (acc == 32'h0);
    end
`endif
  end

  // Query response: stored CDB with live status in byte2, or the miss pattern
  always_comb begin
    q_resp = '0;
    if (q_hit) begin
      q_resp        = slot_cdb[q_idx];
      q_resp[23:16] = slot_status[q_idx];
    end else begin
      q_resp[TAG_WIDTH+15:0] = {8'hFF, bus.query_tag, 8'h00};
    end
  end

  assign bus.cq_cin_ready  = cin_ready;
  assign bus.cmd_err       = trunc_err | do_reject;
  assign bus.cq_cout_ready = !fifo_empty;
  assign bus.cmd_oe        = (eng_state == ENG_STREAM) && !eng_query;
  assign bus.query_oe      = (eng_state == ENG_STREAM) && eng_query;
  assign bus.cmd_out       = bus.cmd_oe   ? snap[IO_WIDTH-1:0] : '0;
  assign bus.query_out     = bus.query_oe ? snap[IO_WIDTH-1:0] : '0;

  // Ingest: shift beats in LSB-first, flag truncation, hand full CDB to the commit cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive       <= 1'b0;
      beat_cnt    <= '0;
      in_buf      <= '0;
      commit_pend <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      alive       <= 1'b1;
      commit_pend <= 1'b0;
      trunc_err   <= 1'b0;
      if (beat_cnt != '0) begin
        if (bus.cmd_ie) begin
          in_buf <= {bus.cmd_in, in_buf[CDB_WIDTH-1:IO_WIDTH]};
          if (beat_cnt == BEAT_LAST) begin
            beat_cnt    <= '0;
            commit_pend <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + BEAT_ONE;
          end
        end else begin
          beat_cnt  <= '0;
          trunc_err <= 1'b1;
        end
      end else if (start_beat) begin
        in_buf   <= {bus.cmd_in, in_buf[CDB_WIDTH-1:IO_WIDTH]};
        beat_cnt <= BEAT_ONE;
      end
    end
  end

  // Slot payload and order FIFO storage (no reset needed, guarded by slot state / pointers)
  always_ff @(posedge clk) begin
    if (do_commit) begin
      slot_cdb[in_idx]                <= in_buf;
      order_mem[wr_ptr[IDX_W-1:0]]    <= in_idx;
    end
  end

  // Slot lifecycle and FIFO pointers; commit, pop and update always hit distinct slot states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_state[i]  <= SLOT_FREE;
        slot_status[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_commit) begin
        slot_state[in_idx]  <= SLOT_PENDING;
        slot_status[in_idx] <= '0;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        slot_state[head_idx] <= SLOT_ISSUED;
        rd_ptr               <= rd_ptr + PTR_ONE;
      end
      if (upd_ok) begin
        slot_status[op_slot] <= bus.cmd_op_status;
        if ((bus.cmd_op_status == 8'd6) || (bus.cmd_op_status == 8'd7))
          slot_state[op_slot] <= SLOT_DONE;
      end
    end
  end

  // Output engine: snapshot at request, one latency cycle, then BEATS beats shifted out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_state <= ENG_IDLE;
      eng_query <= 1'b0;
      eng_beat  <= '0;
      snap      <= '0;
    end else begin
      case (eng_state)
        ENG_IDLE: begin
          if (pop) begin
            snap      <= slot_cdb[head_idx];
            eng_query <= 1'b0;
            eng_state <= ENG_LAT;
          end else if (qry) begin
            snap      <= q_resp;
            eng_query <= 1'b1;
            eng_state <= ENG_LAT;
          end
        end
        ENG_LAT: begin
          eng_beat  <= '0;
          eng_state <= ENG_STREAM;
        end
        ENG_STREAM: begin
          snap <= snap >> IO_WIDTH;
          if (eng_beat == BEAT_LAST) eng_state <= ENG_IDLE;
          else                       eng_beat  <= eng_beat + BEAT_ONE;
        end
        default: eng_state <= ENG_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hv_commandq_gen2.sv
// Directed testbench for hv_commandq_gen2 (default parameters: 64-bit beats, 256-bit CDB, 8 slots).
module tb_hv_commandq_gen2;
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;

  hv_commandq_gen2_if #(.IO_WIDTH(64), .TAG_WIDTH(8)) bus ();
  hv_commandq_gen2 #(.IO_WIDTH(64), .CDB_WIDTH(256), .DEPTH(8), .TAG_WIDTH(8))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] make_cdb(input logic [7:0] op, input logic [7:0] tag,
                                            input logic [31:0] seed);
    logic [255:0] c;
    logic [31:0]  x;
    c = '0;
    c[7:0]  = op;
    c[15:8] = tag;
    for (int w = 1; w < 8; w++) if (w != 4) c[w*32 +: 32] = seed + 32'h0101_0101 * w;
    x = '0;
    for (int w = 0; w < 8; w++) if (w != 4) x = x ^ c[w*32 +: 32];
    c[159:128] = x;
    return c;
  endfunction

  task automatic send_cdb(input logic [255:0] c);
    for (int b = 0; b < 4; b++) begin
      bus.cmd_ie = 1'b1;
      bus.cmd_in = c[b*64 +: 64];
      tick();
    end
    bus.cmd_ie = 1'b0;
    bus.cmd_in = '0;
  endtask

  task automatic run_burst(input bit is_q, input logic [7:0] tag, output logic [255:0] data,
                           output int lat, output int len);
    if (is_q) begin
      bus.query_ie  = 1'b1;
      bus.query_tag = tag;
    end else begin
      bus.cmd_request = 1'b1;
    end
    tick();
    bus.query_ie    = 1'b0;
    bus.cmd_request = 1'b0;
    bus.status_we   = 1'b0;
    lat = 1;
    while (((is_q ? bus.query_oe : bus.cmd_oe) == 1'b0) && lat < 20) begin
      tick();
      lat++;
    end
    len  = 0;
    data = '0;
    while ((is_q ? bus.query_oe : bus.cmd_oe) && len < 8) begin
      if (len < 4) data[len*64 +: 64] = is_q ? bus.query_out : bus.cmd_out;
      tick();
      len++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    vectors++; if (bus.cq_cin_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cin_ready got %b want 0", bus.cq_cin_ready); end
    vectors++; if (bus.cq_cout_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cout_ready got %b want 0", bus.cq_cout_ready); end
    vectors++; if (bus.cmd_err !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_err got %b want 0", bus.cmd_err); end
    vectors++; if ({bus.cmd_oe, bus.query_oe} !== 2'b00) begin miscompares++; $display("FAIL rst_oe got %b want 00", {bus.cmd_oe, bus.query_oe}); end
    vectors++; if (bus.cmd_out !== 64'h0) begin miscompares++; $display("FAIL rst_cmd_out got %h want 0", bus.cmd_out); end
    reset = 1'b1;
    tick();
    tick();
    vectors++; if (bus.cq_cin_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_cin_ready got %b want 1", bus.cq_cin_ready); end
  endtask

  task automatic test_dispatch_order();
    logic [255:0] c [3];
    logic [255:0] d;
    int lat, len;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      c[t] = make_cdb(8'h40, 8'(t), 32'hA000_0000 + t);
      send_cdb(c[t]);
      vectors++; if (bus.cmd_err !== 1'b0) begin miscompares++; $display("FAIL order_err tag%0d got %b want 0", t, bus.cmd_err); end
      tick();
    end
    for (int t = 0; t < 3; t++) begin
      run_burst(1'b0, 8'h00, d, lat, len);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL order_lat tag%0d got %0d want 2", t, lat); end
      vectors++; if (len !== 4) begin miscompares++; $display("FAIL order_len tag%0d got %0d want 4", t, len); end
      vectors++; if (d[31:0] !== (32'h40 | (t << 8))) begin miscompares++; $display("FAIL order_beat0 tag%0d got %h want %h", t, d[31:0], 32'h40 | (t << 8)); end
      vectors++; if (d !== c[t]) begin miscompares++; $display("FAIL order_data tag%0d got %h want %h", t, d, c[t]); end
      vectors++; if (bus.cmd_out !== 64'h0) begin miscompares++; $display("FAIL order_idle_out got %h want 0", bus.cmd_out); end
    end
    vectors++; if (bus.cq_cout_ready !== 1'b0) begin miscompares++; $display("FAIL order_drained got %b want 0", bus.cq_cout_ready); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] c, d;
    int lat, len;
    do_reset();
    c = make_cdb(8'h40, 8'h03, 32'h5555_0000);
    send_cdb(c);
    bus.cmd_request = 1'b1;
    tick();
    bus.cmd_request = 1'b0;
    vectors++; if (bus.cq_cout_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_cout_ready got %b want 1", bus.cq_cout_ready); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.cmd_oe !== 1'b0) begin miscompares++; $display("FAIL b2b_early_pop cycle%0d got %b want 0", i, bus.cmd_oe); end
      tick();
    end
    run_burst(1'b0, 8'h00, d, lat, len);
    vectors++; if (d !== c || lat !== 2) begin miscompares++; $display("FAIL b2b_pop got %h lat %0d want %h lat 2", d, lat, c); end
  endtask

  task automatic test_fill();
    logic [255:0] c0, d;
    int lat, len;
    do_reset();
    c0 = make_cdb(8'h40, 8'h00, 32'h0F0F_0000);
    for (int t = 0; t < 8; t++) begin
      send_cdb(t == 0 ? c0 : make_cdb(8'h41, 8'(t), 32'h1234_0000 + t));
      tick();
    end
    vectors++; if (bus.cq_cin_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full got %b want 0", bus.cq_cin_ready); end
    send_cdb(make_cdb(8'h41, 8'h08, 32'h9999_0000));
    vectors++; if (bus.cmd_err !== 1'b0) begin miscompares++; $display("FAIL fill_ignored_err got %b want 0", bus.cmd_err); end
    tick();
    vectors++; if (bus.cq_cin_ready !== 1'b0) begin miscompares++; $display("FAIL fill_still_full got %b want 0", bus.cq_cin_ready); end
    run_burst(1'b0, 8'h00, d, lat, len);
    vectors++; if (d !== c0) begin miscompares++; $display("FAIL fill_head got %h want %h", d, c0); end
    vectors++; if (bus.cq_cin_ready !== 1'b1) begin miscompares++; $display("FAIL fill_after_pop got %b want 1", bus.cq_cin_ready); end
  endtask

  task automatic test_checksum();
    logic [255:0] c;
    logic exp_err, exp_rdy;
`ifdef HV_CMDQ_CHECKSUM_EN
    exp_err = 1'b1; exp_rdy = 1'b0;
`else
    exp_err = 1'b0; exp_rdy = 1'b1;
`endif
    do_reset();
    c = make_cdb(8'h40, 8'h04, 32'h7777_0000);
    c[159:128] = c[159:128] ^ 32'h1;
    send_cdb(c);
    vectors++; if (bus.cmd_err !== exp_err) begin miscompares++; $display("FAIL csum_err got %b want %b", bus.cmd_err, exp_err); end
    tick();
    vectors++; if (bus.cmd_err !== 1'b0) begin miscompares++; $display("FAIL csum_pulse_width got %b want 0", bus.cmd_err); end
    vectors++; if (bus.cq_cout_ready !== exp_rdy) begin miscompares++; $display("FAIL csum_cout_ready got %b want %b", bus.cq_cout_ready, exp_rdy); end
    do_reset();
    c = make_cdb(8'h40, 8'h05, 32'h3333_0000);
    bus.cmd_ie = 1'b1; bus.cmd_in = c[63:0];    tick();
    bus.cmd_ie = 1'b1; bus.cmd_in = c[127:64];  tick();
    bus.cmd_ie = 1'b0; bus.cmd_in = '0;         tick();
    vectors++; if (bus.cmd_err !== 1'b1) begin miscompares++; $display("FAIL trunc_err got %b want 1", bus.cmd_err); end
    tick();
    vectors++; if (bus.cmd_err !== 1'b0 || bus.cq_cout_ready !== 1'b0) begin miscompares++; $display("FAIL trunc_after got err %b rdy %b want 0 0", bus.cmd_err, bus.cq_cout_ready); end
  endtask

  task automatic test_status_query();
    logic [255:0] c0, c2, d, exp;
    int lat, len;
    do_reset();
    c0 = make_cdb(8'h40, 8'h00, 32'hBEEF_0000);
    send_cdb(c0);
    tick();
    run_burst(1'b0, 8'h00, d, lat, len);
    bus.status_we = 1'b1; bus.op_index = 8'h00; bus.cmd_op_status = 8'h07;
    tick();
    bus.status_we = 1'b0;
    run_burst(1'b1, 8'h00, d, lat, len);
    exp = c0; exp[23:16] = 8'h07;
    vectors++; if (lat !== 2 || len !== 4) begin miscompares++; $display("FAIL query_timing got lat %0d len %0d want 2 4", lat, len); end
    vectors++; if (d !== exp) begin miscompares++; $display("FAIL query_hit got %h want %h", d, exp); end
    run_burst(1'b1, 8'h09, d, lat, len);
    exp = '0; exp[63:0] = 64'h0000_0000_00FF_0900;
    vectors++; if (d !== exp || len !== 4) begin miscompares++; $display("FAIL query_miss got %h len %0d want %h len 4", d, len, exp); end
    c2 = make_cdb(8'h40, 8'h02, 32'hCAFE_0000);
    send_cdb(c2);
    tick();
    run_burst(1'b0, 8'h00, d, lat, len);
    bus.status_we = 1'b1; bus.op_index = 8'h02; bus.cmd_op_status = 8'h06;
    run_burst(1'b1, 8'h02, d, lat, len);
    vectors++; if (d[23:16] !== 8'h00) begin miscompares++; $display("FAIL query_old_status got %h want 00", d[23:16]); end
    run_burst(1'b1, 8'h02, d, lat, len);
    vectors++; if (d[23:16] !== 8'h06) begin miscompares++; $display("FAIL query_new_status got %h want 06", d[23:16]); end
  endtask

  task automatic test_collision();
    logic [255:0] c, d;
    int lat, len;
    do_reset();
    c = make_cdb(8'h40, 8'h01, 32'h4242_0000);
    send_cdb(c);
    tick();
    run_burst(1'b0, 8'h00, d, lat, len);
    send_cdb(c);
    vectors++; if (bus.cmd_err !== 1'b1) begin miscompares++; $display("FAIL coll_issued got %b want 1", bus.cmd_err); end
    tick();
    vectors++; if (bus.cq_cout_ready !== 1'b0) begin miscompares++; $display("FAIL coll_not_queued got %b want 0", bus.cq_cout_ready); end
    bus.status_we = 1'b1; bus.op_index = 8'h09; bus.cmd_op_status = 8'h06;
    tick();
    bus.status_we = 1'b0;
    send_cdb(c);
    vectors++; if (bus.cmd_err !== 1'b1) begin miscompares++; $display("FAIL coll_tag_mismatch_drop got %b want 1", bus.cmd_err); end
    tick();
    bus.status_we = 1'b1; bus.op_index = 8'h01; bus.cmd_op_status = 8'h06;
    tick();
    bus.status_we = 1'b0;
    send_cdb(c);
    vectors++; if (bus.cmd_err !== 1'b0) begin miscompares++; $display("FAIL coll_done_accept got %b want 0", bus.cmd_err); end
    tick();
    vectors++; if (bus.cq_cout_ready !== 1'b1) begin miscompares++; $display("FAIL coll_requeued got %b want 1", bus.cq_cout_ready); end
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] c, d, exp;
    int lat, len;
    do_reset();
    c = make_cdb(8'h40, 8'h05, 32'h6060_0000);
    send_cdb(c);
    tick();
    bus.cmd_request = 1'b1;
    tick();
    bus.cmd_request = 1'b0;
    tick();
    tick();
    tick();
    vectors++; if (bus.cmd_oe !== 1'b1 || bus.cmd_out !== c[191:128]) begin miscompares++; $display("FAIL mid_beat2 got oe %b %h want 1 %h", bus.cmd_oe, bus.cmd_out, c[191:128]); end
    reset = 1'b0;
    #1;
    vectors++; if (bus.cmd_oe !== 1'b0 || bus.cmd_out !== 64'h0) begin miscompares++; $display("FAIL mid_reset_drop got oe %b %h want 0 0", bus.cmd_oe, bus.cmd_out); end
    tick();
    reset = 1'b1;
    tick();
    tick();
    vectors++; if (bus.cq_cout_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset_cout got %b want 0", bus.cq_cout_ready); end
    run_burst(1'b1, 8'h05, d, lat, len);
    exp = '0; exp[63:0] = 64'h0000_0000_00FF_0500;
    vectors++; if (d !== exp) begin miscompares++; $display("FAIL mid_reset_free got %h want %h", d, exp); end
  endtask

  initial begin
    reset = 1'b0;
    bus.cmd_ie = 1'b0; bus.cmd_in = '0; bus.cmd_request = 1'b0;
    bus.status_we = 1'b0; bus.op_index = '0; bus.cmd_op_status = '0;
    bus.query_ie = 1'b0; bus.query_tag = '0;
    test_reset();
    test_dispatch_order();
    test_back_to_back();
    test_fill();
    test_checksum();
    test_status_query();
    test_collision();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hv_commandq_gen2.md
Name: hv_commandq_gen2

Overview:
Second-generation host command queue. It ingests fixed-size command descriptor blocks (CDBs) as IO_WIDTH-bit beats and checks their XOR checksum. Accepted CDBs are held in a DEPTH-entry slot store indexed by tag. The block dispatches CDBs in arrival order to the back-end, tracks per-tag completion status, and answers host status queries. It replaces the fixed 64-bit/256-bit single-mode command queue between the host command decoder and the back-end sequencer.

Parameters:
IO_WIDTH, 64, beat width of cmd_in/cmd_out/query_out
CDB_WIDTH, 256, CDB size in bits; must be a multiple of IO_WIDTH; BEATS = CDB_WIDTH/IO_WIDTH, BEATS >= 2
DEPTH, 8, number of slots; power of 2, 2..64
TAG_WIDTH, 8, tag width; slot index = tag[log2(DEPTH)-1:0]

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
cmd_ie  in  1  CDB beat valid
cmd_in  in  IO_WIDTH  CDB beat; beat 0 carries the LSBs
cq_cin_ready  out  1  a new CDB may start
cmd_err  out  1  one-cycle pulse: CDB rejected
cmd_request  in  1  one-cycle pop request
cq_cout_ready  out  1  at least one PENDING CDB is queued
cmd_oe  out  1  cmd_out beat valid
cmd_out  out  IO_WIDTH  dispatched CDB beat
status_we  in  1  status update strobe
op_index  in  TAG_WIDTH  tag being updated
cmd_op_status  in  8  new status code
query_ie  in  1  one-cycle query strobe
query_tag  in  TAG_WIDTH  tag queried
query_oe  out  1  query_out beat valid
query_out  out  IO_WIDTH  query response beat

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; all slots FREE; order FIFO empty; beat and dispatch counters 0.
- CDB fields: byte0 = opcode, byte1 = tag, byte2 = status field; 32-bit word 4 = checksum.
- Ingest start: a CDB starts on a cmd_ie cycle with the beat counter at 0 and cq_cin_ready=1. If cq_cin_ready=0, cmd_ie is ignored.
- Ingest body: BEATS consecutive cmd_ie cycles are required. If cmd_ie drops mid-CDB, the partial CDB is discarded, the counter resets, and cmd_err pulses the next cycle.
- Ingest commit: one cycle after the last beat, the CDB is committed or rejected.
  - Commit: slot gets the CDB, state PENDING, status 0; slot index pushed to the order FIFO.
  - Reject with cmd_err pulse when the checksum fails or the target slot is PENDING or ISSUED (tag collision). FREE and DONE slots are overwritable.
- cq_cin_ready = (FIFO count < DEPTH) AND no commit in progress.
- Dispatch: cmd_request is honoured only when cq_cout_ready=1 and no dispatch or query is streaming; otherwise it is ignored with no side effects.
  - cmd_oe rises 2 cycles after the request and stays high exactly BEATS cycles; cmd_out carries beats 0..BEATS-1 in order.
  - The slot is popped and goes to ISSUED on the request cycle.
  - Outside cmd_oe, cmd_out = 0.
- Status update: status_we writes cmd_op_status to the slot addressed by op_index, only if the slot is ISSUED and its stored tag equals op_index; otherwise the write is dropped.
  - Status 6 (READ_DONE) or 7 (WRITE_DONE) moves the slot to DONE; any other code keeps it ISSUED.
- Query: query_ie starts a response; query_oe rises 2 cycles later for BEATS cycles. A query_ie while a dispatch or query is streaming is ignored.
  - Hit (slot not FREE, stored tag = query_tag): response = the stored CDB with byte2 of beat 0 replaced by the current status.
  - Miss: beat 0 = {zeros, 8'hFF, query_tag, 8'h00}; other beats = 0.
- Same-cycle events, in priority order:
  - Commit and cmd_request: the new entry is not poppable until the next cycle.
  - status_we and query on the same slot: the query sees the old status.
  - A commit into a DONE slot while a query streams that slot: the query streams a snapshot latched at query_ie.
- FIFO wrap-around: pointers are log2(DEPTH)+1 bits; full when MSBs differ and LSBs match.

Optional Feature:
HV_CMDQ_CHECKSUM_EN:
- Defined: checksum verification is active. Word 4 must equal the XOR of all other 32-bit words of the CDB; CDB_WIDTH must be at least 160.
- Undefined: no checksum check. Word 4 is stored unchanged, and the only reject causes are truncation and collision.

Test Plan:
- Three BSM_WRITE (0x40) CDBs with tags 0,1,2 and valid checksums, then 3 cmd_request pulses -> three cmd_oe bursts of 4 beats each, in tag order 0,1,2, with beat 0 = 0x..._0000_0040 + (tag<<8); no cmd_err.
- Eight CDBs with tags 0..7 (DEPTH=8), none popped -> cq_cin_ready=0 after the 8th commit; a 9th cmd_ie burst is ignored; one pop -> cq_cin_ready=1.
- CDB with checksum word XOR 0x1 -> cmd_err pulses 1 cycle after the last beat; cq_cout_ready stays 0. With the macro undefined -> accepted.
- Dispatch tag 0, status_we op_index=0 status=7, query tag 0 -> query_oe for 4 cycles; beat 0 byte2 = 0x07. Query tag 9 (never written) -> beat 0 = 0x0000_0000_00FF_0900.
- Resend tag 1 while slot 1 is ISSUED -> cmd_err; after status 6 on tag 1, the resend is accepted.
- Assert reset mid-burst (cmd_oe=1, beat 2) -> cmd_oe drops immediately; after release all slots are FREE and cq_cout_ready=0.
